// File: rtl/sm_tc_pkg.sv
// Shared types for the sign-magnitude / two's-complement converter:
// the per-beat conversion mode and the correction flags that travel with each word.
package sm_tc_pkg;

  typedef enum logic {
    MODE_SM2TC = 1'b0,
    MODE_TC2SM = 1'b1
  } mode_e;

  typedef struct packed {
    logic negz;
    logic sat;
  } flags_t;

endpackage

// File: rtl/sm_tc_core.sv
// Combinational SM <-> TC conversion for one word, with flag generation.
// In both directions a negative word keeps its sign bit, and its low bits become
// the two's-complement negation of the low bits. The two words whose magnitude
// field is zero are the special cases:
//   SM -0      -> TC 0,            flagged negz
//   TC -2^(W-1) -> SM -(2^(W-1)-1), flagged sat (the true value has no SM code)
module sm_tc_core
  import sm_tc_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  output logic [WIDTH-1:0] dout,
  output flags_t           flags
);

  logic [WIDTH-2:0] mag;
  logic [WIDTH-2:0] mag_neg;

  assign mag     = din[WIDTH-2:0];
  assign mag_neg = -mag;

  // Pick the converted word and raise the matching flag on the zero-magnitude case.
  always_comb begin
    dout  = din;
    flags = '0;
    if (din[WIDTH-1]) begin
      if (mag == '0) begin
        if (mode == MODE_SM2TC) begin
          dout       = '0;
          flags.negz = 1'b1;
        end else begin
          dout      = '1;
          flags.sat = 1'b1;
        end
      end else begin
        dout = {1'b1, mag_neg};
      end
    end
  end

endmodule

// File: rtl/sm_tc_conv_pipe.sv
// Streaming SM <-> TC converter with valid/ready on both sides.
// Conversion happens on the input side; results land in an output register,
// or in a single skid register when the output is still waiting to be taken.
// in_ready is registered and simply reflects an empty skid register.
// Optional build macro: CONV_STATS_EN adds stat_clr plus saturating
// negz_cnt / sat_cnt counters of flagged beats accepted at the output.
module sm_tc_conv_pipe
  import sm_tc_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int TAG_W = 1
`ifdef CONV_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
`ifdef CONV_STATS_EN
  input  logic             stat_clr,
  output logic [CNT_W-1:0] negz_cnt,
  output logic [CNT_W-1:0] sat_cnt,
`endif
  output logic             out_negz,
  output logic             out_sat
);

  logic [WIDTH-1:0] conv_data;
  flags_t           conv_flags;
  flags_t           out_flags;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;
  flags_t           skid_flags;
  logic             in_fire;
  logic             out_fire;

  sm_tc_core #(.WIDTH(WIDTH)) u_core (
    .din   (in_data),
    .mode  (in_mode),
    .dout  (conv_data),
    .flags (conv_flags)
  );

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_negz = out_flags.negz;
  assign out_sat  = out_flags.sat;

  // Output/skid storage. A full skid blocks input, so in_fire never coincides with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
      skid_flags <= '0;
      in_ready   <= 1'b1;
    end else if (skid_valid) begin
      if (out_fire) begin
        out_data   <= skid_data;
        out_tag    <= skid_tag;
        out_flags  <= skid_flags;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end
    end else if (in_fire) begin
      if (!out_valid || out_fire) begin
        out_valid <= 1'b1;
        out_data  <= conv_data;
        out_tag   <= in_tag;
        out_flags <= conv_flags;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= conv_data;
        skid_tag   <= in_tag;
        skid_flags <= conv_flags;
        in_ready   <= 1'b0;
      end
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CONV_STATS_EN
  // Saturating counters of flagged beats taken downstream; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negz_cnt <= '0;
      sat_cnt  <= '0;
    end else if (stat_clr) begin
      negz_cnt <= '0;
      sat_cnt  <= '0;
    end else if (out_fire) begin
      if (out_flags.negz && (negz_cnt != '1)) negz_cnt <= negz_cnt + CNT_W'(1);
      if (out_flags.sat && (sat_cnt != '1))   sat_cnt  <= sat_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sm_tc_conv_pipe.sv
// Self-checking bench for sm_tc_conv_pipe: directed literal vectors, backpressure,
// mid-stream reset and a randomized phase, all checked against a value-level model.
module tb_sm_tc_conv_pipe;
  localparam int WIDTH = 3;
  localparam int TAG_W = 1;
`ifdef CONV_STATS_EN
  localparam int CNT_W = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_mode = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_negz;
  logic             out_sat;
`ifdef CONV_STATS_EN
  logic             stat_clr = 1'b0;
  logic [CNT_W-1:0] negz_cnt;
  logic [CNT_W-1:0] sat_cnt;
  int               m_negz = 0;
  int               m_sat = 0;
`endif

  always #5 clk = ~clk;

  sm_tc_conv_pipe #(
    .WIDTH(WIDTH),
    .TAG_W(TAG_W)
`ifdef CONV_STATS_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
`ifdef CONV_STATS_EN
    .stat_clr (stat_clr),
    .negz_cnt (negz_cnt),
    .sat_cnt  (sat_cnt),
`endif
    .out_negz (out_negz),
    .out_sat  (out_sat)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [TAG_W-1:0] t;
    logic             negz;
    logic             sat;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Value-level reference: decode the input as a signed number, re-encode it.
  function automatic beat_t model(input logic [WIDTH-1:0] d, input logic mode,
                                  input logic [TAG_W-1:0] t);
    beat_t b;
    int full, half, s, m, v;
    full = 1 << WIDTH;
    half = 1 << (WIDTH - 1);
    s = int'(d[WIDTH-1]);
    m = int'(d[WIDTH-2:0]);
    b.t = t;
    b.negz = 1'b0;
    b.sat = 1'b0;
    if (mode == 1'b0) begin
      v = (s != 0) ? -m : m;
      if (s != 0 && m == 0) b.negz = 1'b1;
      b.d = WIDTH'((v + full) % full);
    end else begin
      v = (s != 0) ? int'(d) - full : int'(d);
      if (v == -half) begin
        b.sat = 1'b1;
        v = -(half - 1);
      end
      b.d = (v < 0) ? WIDTH'(half - v) : WIDTH'(v);
    end
    return b;
  endfunction

  // Per-cycle compare against the model: occupancy, ready, and head-of-queue payload.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
`ifdef CONV_STATS_EN
      chk("negz_cnt", 32'(negz_cnt), 32'(m_negz));
      chk("sat_cnt", 32'(sat_cnt), 32'(m_sat));
`endif
      if (out_valid && q.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(q[0].d));
        chk("out_tag", 32'(out_tag), 32'(q[0].t));
        chk("out_negz", 32'(out_negz), 32'(q[0].negz));
        chk("out_sat", 32'(out_sat), 32'(q[0].sat));
      end
`ifdef CONV_STATS_EN
      if (stat_clr) begin
        m_negz = 0;
        m_sat = 0;
      end else if (out_valid && out_ready && q.size() > 0) begin
        if (q[0].negz && m_negz < (1 << CNT_W) - 1) m_negz++;
        if (q[0].sat && m_sat < (1 << CNT_W) - 1) m_sat++;
      end
`endif
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(in_data, in_mode, in_tag));
    end
  end

  // One beat into an idle-or-flowing pipe, then literal check of the registered result.
  task automatic dir(input string name, input logic [WIDTH-1:0] d, input logic mode,
                     input logic [WIDTH-1:0] ed, input logic en, input logic es);
    in_valid = 1'b1;
    in_data = d;
    in_mode = mode;
    in_tag = '1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, 32'(out_data), 32'(ed));
    chk({name, "_negz"}, 32'(out_negz), 32'(en));
    chk({name, "_sat"}, 32'(out_sat), 32'(es));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() > 0 || out_valid) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int acc;
    int n;
    beat_t mb;

    // Model self-pins against hand-computed values.
    mb = model(3'b101, 1'b0, '0);
    chk("model_sm2tc_m1", 32'(mb.d), 32'h7);
    mb = model(3'b100, 1'b1, '0);
    chk("model_tc2sm_min", 32'({mb.d, mb.sat}), 32'hF);
    mb = model(3'b110, 1'b1, '0);
    chk("model_tc2sm_m2", 32'(mb.d), 32'h6);

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_flags", 32'({out_negz, out_sat}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    dir("sm2tc_101", 3'b101, 1'b0, 3'b111, 1'b0, 1'b0);
    dir("sm2tc_negz", 3'b100, 1'b0, 3'b000, 1'b1, 1'b0);
    dir("tc2sm_min", 3'b100, 1'b1, 3'b111, 1'b0, 1'b1);
    dir("tc2sm_101", 3'b101, 1'b1, 3'b111, 1'b0, 1'b0);
    dir("sm2tc_pos", 3'b011, 1'b0, 3'b011, 1'b0, 1'b0);
    drain("drain_dir");

    // Mixed modes back-to-back at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data = WIDTH'($urandom);
      in_mode = 1'($urandom);
      in_tag = TAG_W'($urandom);
      @(posedge clk);
      #1;
    end
    drain("drain_mixed");

    // Backpressure: four offers while blocked, only two fit.
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    in_data = WIDTH'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
      if (acc > i) begin
        in_data = WIDTH'($urandom);
        in_mode = 1'($urandom);
        in_tag = TAG_W'($urandom);
      end
    end
    chk("bp_accepts", 32'(acc), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    n = 0;
    while (acc < 3 && n < 10) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_third_accept", 32'(acc), 32'd3);
    drain("drain_bp");

    // Fill output and skid, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 3'b100;
    in_mode = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
`ifdef CONV_STATS_EN
    m_negz = 0;
    m_sat = 0;
`endif
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_stale", 32'(out_valid), 32'd0);
`ifdef CONV_STATS_EN
    chk("post_rst_cnt", 32'({negz_cnt, sat_cnt}), 32'd0);
`endif
    @(posedge clk);
    #1;

`ifdef CONV_STATS_EN
    // Five negative-zero beats saturate a 2-bit counter at 3; clear beats increment.
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 3'b100;
    in_mode = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    drain("drain_negz");
    chk("negz_cnt_sat", 32'(negz_cnt), 32'd3);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    chk("negz_cnt_clr", 32'(negz_cnt), 32'd0);
`endif

    // Randomized traffic with random backpressure and dropping in_valid.
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = WIDTH'($urandom);
      in_mode = 1'($urandom);
      in_tag = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef CONV_STATS_EN
      stat_clr = ($urandom_range(0, 63) == 0);
`endif
      @(posedge clk);
      #1;
    end
`ifdef CONV_STATS_EN
    stat_clr = 1'b0;
`endif
    drain("drain_rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_tc_conv_pipe.md
Name: sm_tc_conv_pipe

Overview:
- Streaming, parametrised number-format converter between sign-magnitude (SM) and two's complement (TC).
- Conversion direction is selected per beat, so each beat carries its own mode.
- Valid/ready handshake on both sides, with a registered in_ready and a 2-entry skid buffer.
- Corrects the negative-zero case and the most-negative unrepresentable case, and flags both.
- Sits between SM-coded datapaths (sensor/ADC side) and TC arithmetic blocks.

Parameters:
- WIDTH, 3, data word width in bits including sign; minimum 2.
- TAG_W, 1, width of a sideband tag carried unchanged with each beat.
- CNT_W, 16, width of each statistics counter; used only with CONV_STATS_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input can accept; registered.
- in_data  input  WIDTH  input word.
- in_mode  input  1  0 = SM→TC, 1 = TC→SM.
- in_tag  input  TAG_W  sideband, passed through.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  converted word.
- out_tag  output  TAG_W  tag of this beat.
- out_negz  output  1  input was SM negative zero.
- out_sat  output  1  input was TC most-negative; output saturated.

Behaviour:
- Reset (asynchronous, active-low): out_valid=0, out_data=0, out_tag=0, out_negz=0, out_sat=0, skid empty, in_ready=1.
- Reset asserted mid-operation discards all buffered beats immediately.
- Handshake:
  - Transfer occurs on any edge where valid&&ready.
  - out_valid and its payload hold stable until accepted.
  - in_valid may drop without a transfer.
- Latency: 1 cycle from input acceptance to out_valid. Full throughput of one beat per cycle while out_ready=1.
- Storage is an output register plus one skid register.
  - If the output register holds an unaccepted beat when a beat is accepted, the new beat goes to skid.
  - in_ready next = !(skid will be occupied).
  - When output is accepted and skid is occupied, skid moves to output in the same edge.
  - Simultaneous accept-in and accept-out with skid empty: output loads the new beat directly.
  - Order is always preserved and no beat is lost or duplicated.
- Conversion is combinational before the output/skid registers. Let S=in_data[WIDTH-1] and M=in_data[WIDTH-2:0].
  - SM→TC, S=0: out=in_data.
  - SM→TC, S=1 with M≠0: out={1, ~M+1} truncated to WIDTH-1 bits.
  - SM→TC, S=1 with M=0 (negative zero): out=0, negz=1.
  - TC→SM, S=0: out=in_data.
  - TC→SM, S=1 with M≠0: out={1,(~in_data+1)[WIDTH-2:0]}.
  - TC→SM, in_data=100…0: out={1, all ones}, i.e. -(2^(WIDTH-1)-1), sat=1.
- Flags are registered alongside their data and are valid only while out_valid=1.

Optional Feature:
- Macro: CONV_STATS_EN.
- When defined, adds:
  - input stat_clr;
  - outputs negz_cnt[CNT_W] and sat_cnt[CNT_W].
- Counting rules:
  - Each counter increments when a beat with the corresponding flag is accepted at the output.
  - Counters saturate at all-ones and reset to 0.
  - stat_clr is synchronous and takes priority over an increment in the same cycle.
- When undefined, these ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Package sm_tc_pkg holds:
  - the mode typedef (MODE_SM2TC=1'b0, MODE_TC2SM=1'b1);
  - the flag struct {negz, sat}.
- One combinational sub-module, sm_tc_core, holds the WIDTH-parametrised conversion and flag generation. The top instantiates it once, on the input side.

Test Plan:
- WIDTH=3, SM→TC, in=3'b101 with out_ready=1 → next cycle out=3'b111, negz=0, sat=0.
- SM→TC, in=3'b100 → out=3'b000, negz=1.
- TC→SM, in=3'b100 → out=3'b111, sat=1.
- TC→SM, in=3'b101 → out=3'b111, sat=0.
- Mixed modes back-to-back at full rate → correct per-beat conversion with tags intact.
- Backpressure: out_ready=0 for 4 cycles while offering 4 beats → exactly 2 accepted, in_ready=0 from the cycle after the second accept. Release out_ready → beats emerge in order, the next input is accepted, and nothing is lost.
- Reset mid-stream with output and skid both full → out_valid=0 asynchronously. After release: in_ready=1, no stale beat, and with CONV_STATS_EN counters=0.
- With CONV_STATS_EN, CNT_W=2, 5 negz beats → negz_cnt=3. stat_clr coincident with a negz beat → 0.
